// File: rtl/aes_key_expand_multi.sv
// AES-128/192/256 key schedule engine with an indexed round-key store.
// Optional zeroize port and idle auto-clear: AES_KEY_EXPAND_ZEROIZE_EN.

module aes_sbox_lut (
    input  logic [7:0] a,
    output logic [7:0] d
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // byte a sits at the MSB end of the table, so offset by 255-a
    assign d = SBOX[{~a, 3'b000} +: 8];

endmodule

module aes_key_expand_multi #(
    parameter int MAX_NK      = 8,
    parameter int STORE_WORDS = 4*(MAX_NK+7),
    parameter int RD_IDX_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
    input  logic                key_clr,
`endif
    input  logic                kld,
    input  logic [1:0]          key_len,
    input  logic [255:0]        key,
    output logic                busy,
    output logic                done,
    output logic                key_err,
    input  logic [RD_IDX_W-1:0] rk_rd_idx,
    output logic [127:0]        rk_rd_data,
    output logic                rk_rd_vld
);

    localparam int AW = $clog2(STORE_WORDS);
    localparam int IW = $clog2(STORE_WORDS+1);

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t          state_q, state_d;
    logic [3:0]      nk_q, nr_q, cnt_q;
    logic [IW-1:0]   i_q;
    logic [7:0]      rcon_q;
    logic            done_q, done_d;
    logic            err_q;
    logic [31:0]     hist_q  [MAX_NK];
    logic [31:0]     store_q [STORE_WORDS];

    logic [3:0]      nk_new, nr_new;
    logic            len_ok, ld_ok, ld_bad, step, last, clr;
    logic [31:0]     kw      [8];
    logic [31:0]     hist_ld [MAX_NK];
    logic [31:0]     temp, sb_in, sb_out, t2, w_old, w_new;
    logic [IW-1:0]   t_last;
    logic [AW-1:0]   rd_base;
    logic            rd_ok;

`ifdef AES_KEY_EXPAND_ZEROIZE_EN
    logic [15:0]     idle_q;
    logic            idle_sat;

    assign idle_sat = (state_q == READY) && (idle_q == 16'hffff);
    assign clr      = key_clr | idle_sat;

    // idle timer runs only while a finished schedule sits unused
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_q <= '0;
        else if (state_q != READY || kld)
            idle_q <= '0;
        else if (!idle_sat)
            idle_q <= idle_q + 16'd1;
    end
`else
    assign clr = 1'b0;
`endif

    // key length decode; lengths above MAX_NK are rejected
    always_comb begin
        len_ok = 1'b1;
        nk_new = 4'd4;
        nr_new = 4'd10;
        unique case (key_len)
            2'b00: begin nk_new = 4'd4; nr_new = 4'd10; end
            2'b01: begin nk_new = 4'd6; nr_new = 4'd12; end
            2'b10: begin nk_new = 4'd8; nr_new = 4'd14; end
            default: len_ok = 1'b0;
        endcase
        if (int'(nk_new) > MAX_NK)
            len_ok = 1'b0;
    end

    assign ld_ok  = kld & len_ok & ~clr;
    assign ld_bad = kld & ~len_ok & ~clr;
    assign t_last = IW'({nr_q, 2'b00} + 6'd3);
    assign last   = (i_q == t_last);

    // next-state and control; a legal load aborts any expansion
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        step    = 1'b0;
        if (clr)
            state_d = IDLE;
        else if (ld_ok)
            state_d = EXPAND;
        else if (ld_bad)
            state_d = IDLE;
        else begin
            case (state_q)
                EXPAND: begin
                    step = 1'b1;
                    if (last) begin
                        state_d = READY;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    assign busy    = (state_q == EXPAND);
    assign done    = done_q;
    assign key_err = err_q;

    // key words and history image for the load cycle (newest at tap 0)
    always_comb begin
        for (int m = 0; m < 8; m++)
            kw[m] = key[255-32*m -: 32];
        for (int j = 0; j < MAX_NK; j++) begin
            hist_ld[j] = '0;
            for (int m = 0; m < MAX_NK; m++)
                if (int'(nk_new) - 1 - j == m)
                    hist_ld[j] = kw[m];
        end
    end

    // one schedule word: shared SubWord for both rotate and Nk=8 cases
    always_comb begin
        temp  = hist_q[0];
        sb_in = (cnt_q == 4'd0) ? {temp[23:0], temp[31:24]} : temp;
        w_old = '0;
        for (int j = 0; j < MAX_NK; j++)
            if (int'(nk_q) - 1 == j)
                w_old = hist_q[j];
        if (cnt_q == 4'd0)
            t2 = sb_out ^ {rcon_q, 24'h0};
        else if (nk_q == 4'd8 && cnt_q == 4'd4)
            t2 = sb_out;
        else
            t2 = temp;
        w_new = w_old ^ t2;
    end

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox_lut u_sbox (
            .a (sb_in[8*b +: 8]),
            .d (sb_out[8*b +: 8])
        );
    end

    // counters, round constant, latched key geometry and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nk_q   <= 4'd4;
            nr_q   <= 4'd10;
            i_q    <= '0;
            cnt_q  <= '0;
            rcon_q <= 8'h01;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
            if (clr) begin
                i_q   <= '0;
                err_q <= 1'b0;
            end else if (ld_ok) begin
                nk_q   <= nk_new;
                nr_q   <= nr_new;
                i_q    <= IW'(nk_new);
                cnt_q  <= '0;
                rcon_q <= 8'h01;
                err_q  <= 1'b0;
            end else if (ld_bad) begin
                i_q   <= '0;
                err_q <= 1'b1;
            end else if (step) begin
                i_q   <= i_q + IW'(1);
                cnt_q <= (cnt_q == nk_q - 4'd1) ? 4'd0 : cnt_q + 4'd1;
                if (cnt_q == 4'd0)
                    rcon_q <= {rcon_q[6:0], 1'b0} ^
                              (rcon_q[7] ? 8'h1b : 8'h00);
            end
        end
    end

    // history shift buffer holding the last MAX_NK words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < MAX_NK; j++)
                hist_q[j] <= '0;
        end else if (clr) begin
            for (int j = 0; j < MAX_NK; j++)
                hist_q[j] <= '0;
        end else if (ld_ok) begin
            for (int j = 0; j < MAX_NK; j++)
                hist_q[j] <= hist_ld[j];
        end else if (step) begin
            hist_q[0] <= w_new;
            for (int j = 1; j < MAX_NK; j++)
                hist_q[j] <= hist_q[j-1];
        end
    end

    // round-key store: key words on load, one expanded word per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < STORE_WORDS; j++)
                store_q[j] <= '0;
        end else if (clr) begin
            for (int j = 0; j < STORE_WORDS; j++)
                store_q[j] <= '0;
        end else begin
            if (step)
                for (int j = 0; j < STORE_WORDS; j++)
                    if (int'(i_q) == j)
                        store_q[j] <= w_new;
            if (ld_ok)
                for (int j = 0; j < MAX_NK; j++)
                    if (j < int'(nk_new))
                        store_q[j] <= kw[j];
        end
    end

    assign rd_base = AW'({rk_rd_idx, 2'b00});
    assign rd_ok   = int'(rk_rd_idx) <= int'(nr_q);

    // registered read port, validity judged against the current i
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_rd_data <= '0;
            rk_rd_vld  <= 1'b0;
        end else if (clr) begin
            rk_rd_data <= '0;
            rk_rd_vld  <= 1'b0;
        end else begin
            rk_rd_data <= rd_ok ? {store_q[rd_base],
                                   store_q[rd_base + AW'(1)],
                                   store_q[rd_base + AW'(2)],
                                   store_q[rd_base + AW'(3)]} : '0;
            rk_rd_vld  <= rd_ok &&
                          (int'(rk_rd_idx)*4 + 3 < int'(i_q));
        end
    end

endmodule

// File: doc/aes_key_expand_multi.md
Name: aes_key_expand_multi

Overview:
Parametrised AES key-schedule engine for 128-, 192- and 256-bit keys, selected per load. The key length is fixed for the duration of each expansion.
- Expands one 32-bit schedule word per cycle into an internal round-key store.
- The cipher datapath reads any round key 0..Nr by index; the key is not streamed in lockstep.
- Sits beside the AES round datapath and replaces the 128-bit-only on-the-fly expander.
- Keys can be reused across many blocks without re-expansion.

Parameters:
MAX_NK, 8, largest supported key length in words. Legal values 4, 6, 8; sizes the history buffer and the store.
STORE_WORDS, 4*(MAX_NK+7), round-key store depth in 32-bit words. Default 60.
RD_IDX_W, 4, width of the round-key read index.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
kld  in  1  single-cycle load/start strobe; samples key and key_len.
key_len  in  2  key length select: 00 = 128, 01 = 192, 10 = 256, 11 = illegal.
key  in  256  key; key[255:224] = w[0]. Words beyond Nk are ignored.
busy  out  1  expansion in progress.
done  out  1  one-cycle pulse when the final word has been written.
key_err  out  1  sticky flag: last kld had illegal or unsupported key_len.
rk_rd_idx  in  RD_IDX_W  round-key index to read.
rk_rd_data  out  128  registered round key {w[4k], w[4k+1], w[4k+2], w[4k+3]}.
rk_rd_vld  out  1  registered flag: rk_rd_data is complete and valid.

Behaviour:
- Reset values: all outputs 0; store words 0; FSM in IDLE; word counter i = 0; Nk = 4; Nr = 10.
- Nk/Nr are latched at kld: 4/10, 6/12, 8/14. Total words T = 4*(Nr+1), i.e. 44/52/60.
- FSM states: IDLE, EXPAND, READY.
- Illegal kld (key_len = 11, or Nk > MAX_NK):
  - key_err is set and the FSM goes to IDLE.
  - The store is left untouched and rk_rd_vld reads 0.
- Legal kld, from any state:
  - Clears key_err.
  - Writes w[0..Nk-1] to the store and the history buffer in the same cycle; sets i = Nk and rcon = 01.
  - Enters EXPAND. This aborts any running expansion.
- EXPAND computes one word per cycle, with temp = w[i-1]:
  - i mod Nk = 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon); xtime reduces by 8'h1b on overflow.
  - Nk = 8 and i mod Nk = 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp; it is stored and i increments.
  - A modulo-Nk counter tracks i mod Nk; no divider is used.
- SubWord uses four aes_sbox_lut instances, shared by both SubWord cases.
- History: an 8-entry shift buffer holds the last MAX_NK words. w[i-Nk] is selected from the Nk tap.
- Expansion latency from the kld edge: T-Nk cycles, i.e. 40/46/52. busy is high for exactly those cycles.
- Completion: in the cycle the word with i = T-1 is written, the FSM moves to READY and done pulses for one cycle. done is registered, so it is seen on the next edge.
- READY holds the store until the next kld; busy = 0.
- Read path has 1-cycle latency; rk_rd_data/rk_rd_vld reflect the rk_rd_idx sampled on the previous edge.
- rk_rd_vld = 1 iff rk_rd_idx ≤ Nr and 4*rk_rd_idx+3 < i, using i at sample time.
  - Reads during EXPAND are legal, so round 0 is valid immediately after kld.
  - Incomplete entries return their current contents with rk_rd_vld = 0.
  - rk_rd_idx > Nr returns 128'h0 with rk_rd_vld = 0.
- A kld coincident with a read: the read returns the pre-load contents, and rk_rd_vld is computed with the old i.
- Asynchronous reset mid-EXPAND: immediate return to reset values. No partial key survives in the store.

Optional Feature:
AES_KEY_EXPAND_ZEROIZE_EN
- With the macro:
  - Adds input port key_clr (1 bit).
  - key_clr = 1 zeroes all store and history words and rk_rd_data in one cycle.
  - The FSM goes to IDLE with done suppressed and key_err cleared.
  - key_clr has priority over a simultaneous kld; the kld is dropped.
  - READY also auto-zeroizes: after a 16-bit idle counter saturates with no kld, the same clear is applied.
- Without the macro: no key_clr port and no idle counter. Store contents persist until the next legal kld or reset.

Test Plan:
- 128-bit key 2b7e1516 28aed2a6 abf71588 09cf4f3c -> busy high 40 cycles, done pulse. Reading idx 10 returns d014f9a8 c9ee2589 e13f0cc8 b6630ca6 with rk_rd_vld = 1.
- 192-bit key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> 46 busy cycles. idx 12 returns e98ba06f 448c773c 8ecc7204 01002202; idx 13 returns 0 with vld = 0.
- 256-bit key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> 52 busy cycles. idx 14 returns fe4890d1 e6188d0b 046df344 706c631e.
- kld of a 256-bit key, a second kld with a 128-bit key 20 cycles later, then reads -> no done from the first load. done arrives 40 cycles after the second kld, and the store matches the 128-bit vector.
- key_len = 11 -> key_err = 1, busy = 0, all reads have vld = 0. A following legal kld clears key_err.
- Read idx 1 every cycle during a 128-bit expansion -> vld rises exactly on the read sampled after w[7] is written. rst_n low mid-expansion -> all outputs 0 immediately.
